imm_extend_seq: RTL and testbench
=================================

# imm_extend_seq

Parametrised, multi-cycle immediate-generation unit for the ARM decode stage. It accepts the 24-bit instruction immediate field through a valid/ready handshake. It produces the extended immediate and the shifter carry-out. Rotated 8-bit immediates go through an iterative rotator that handles ROT_STEP bits per cycle, which trades latency for area. It supersedes the single-cycle combinational extender.

## Interface
- DATA_W, 32, result width; even, ≥ 32
- ROT_STEP, 2, maximum rotate bits per iteration; one of 2, 4, 8, 16
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request
- instr  in  24  instruction bits [23:0]
- imm_src  in  3  mode select, imm_src_e
- carry_in  in  1  current C flag, passed through when the rotate amount is 0
- flush  in  1  synchronous abort of any in-flight request
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer takes the result
- ext_imm  out  DATA_W  extended immediate
- carry_out  out  1  shifter carry-out
- illegal  out  1  reserved imm_src was accepted; valid with out_valid

## Operation
- Modes:
  - ROT8 (000): zero-extend instr[7:0] to DATA_W, then rotate right over DATA_W by amount = 2·instr[11:8] (0..30).
  - ZEXT12 (001): result = zero-extended instr[11:0].
  - BRANCH (010): result = sign-extended {instr[23:0], 2'b00}.
  - HALF8 (011): result = zero-extended {instr[11:8], instr[3:0]}.
  - SEXT12 (100): result = sign-extended instr[11:0].
  - 101–111: result 0, illegal = 1.
- carry_out:
  - ROT8 with amount ≠ 0: final ext_imm[DATA_W-1].
  - All other cases: carry_in captured at accept.
- FSM states: IDLE, ROT, DONE.
  - IDLE: in_ready = 1. Accept when in_valid & in_ready.
    - ROT8 with amount > 0: load work = zext(imm8) and rem = amount, go to ROT.
    - Otherwise: load the final result, go to DONE.
  - ROT: each cycle rotates work right by s = min(ROT_STEP, rem), then rem -= s. Go to DONE when rem becomes 0.
  - DONE: out_valid = 1. ext_imm, carry_out and illegal stay stable until out_valid & out_ready, then go to IDLE.
- in_ready is 0 in ROT and DONE. No accept in the cycle the result is consumed.
- flush: from any state, go to IDLE next edge and drop the request. If flush and in_valid are both high in IDLE, nothing is accepted (flush wins).
- Reset values: state IDLE, in_ready 0 while reset is asserted then 1, out_valid 0, ext_imm 0, carry_out 0, illegal 0, rem 0.
- Reset during ROT or DONE abandons the request. No output appears after reset releases.

## Timing
- Accept on edge E. k = ceil(amount / ROT_STEP). k = 0 for non-rotating modes and for ROT8 with amount 0.
- out_valid is high in the cycle after edge E+k and holds until the handshake.
- Worst case: amount 30 with ROT_STEP 2 gives k = 15.
- Throughput: one request per k+2 cycles when out_ready is held high.
- Outputs are registered. There are no combinational input-to-output paths except in_ready, which is a function of state.

## Structure
- Package imm_pkg:
  - imm_src_e enum for the modes above.
  - ROT_FIELD_W = 4.
  - State enum for IDLE, ROT, DONE.
- Sub-module ror_step: combinational rotate-right of a DATA_W word by 0..ROT_STEP bits. It is instantiated once inside the ROT datapath.

## Test plan
- ROT8, instr[11:0]=0x4FF, ROT_STEP=2 -> ext_imm 0xFF000000, carry_out 1, out_valid after E+4.
- Same request with ROT_STEP=16 -> same result after E+1.
- ROT8, instr[11:0]=0x0AB, carry_in=1 -> ext_imm 0x000000AB, carry_out 1, k=0.
- BRANCH, instr=0xFFFFFE -> 0xFFFFFFF8.
- ZEXT12 with 0xABC -> 0x00000ABC. SEXT12 with 0x800 -> 0xFFFFF800. HALF8 with instr[11:0]=0xA05 -> 0x000000A5. imm_src=110 -> ext_imm 0, illegal 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready 0. Then 1 cycle of out_ready -> IDLE, and the next request is accepted the cycle after.
- Assert reset at ROT iteration 2 of 0xFFF (amount 30) -> immediate IDLE with all outputs 0, no stale out_valid. Assert flush in ROT -> IDLE next edge, request dropped.

Source files
------------

// File: rtl/imm_extend_seq_pkg.sv
// imm_pkg: immediate-source modes, field widths and FSM states for imm_extend_seq
package imm_pkg;
  typedef enum logic [2:0] {
    ROT8   = 3'b000,
    ZEXT12 = 3'b001,
    BRANCH = 3'b010,
    HALF8  = 3'b011,
    SEXT12 = 3'b100
  } imm_src_e;
  localparam int ROT_FIELD_W = 4;
  typedef enum logic [1:0] {IDLE, ROT, DONE} state_e;
endpackage

// File: rtl/imm_extend_seq_ror_step.sv
// ror_step: combinational rotate-right of a DATA_W word by 0..ROT_STEP bits
module ror_step #(
  parameter int DATA_W = 32,
  parameter int ROT_STEP = 2
) (
  input  logic [DATA_W-1:0]                din,
  input  logic [$clog2(ROT_STEP+1)-1:0]    amt,
  output logic [DATA_W-1:0]                dout
);
  // a left shift by DATA_W yields zero, so amt == 0 passes din through
  assign dout = (din >> amt) | (din << (DATA_W - 32'(amt)));
endmodule

// File: rtl/imm_extend_seq.sv
// imm_extend_seq: multi-cycle ARM immediate extender with an iterative ROT_STEP-bit rotator
module imm_extend_seq
  import imm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ROT_STEP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       instr,
  input  logic [2:0]        imm_src,
  input  logic              carry_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_imm,
  output logic              carry_out,
  output logic              illegal
);
  localparam int AW = ROT_FIELD_W + 1;
  localparam int SW = $clog2(ROT_STEP + 1);
  state_e state, state_nx;
  logic [AW-1:0] amt, rem;
  logic [SW-1:0] step;
  logic [DATA_W-1:0] imm8, final_imm, rot;
  logic accept, rot_go, last;
  assign amt = {instr[8 +: ROT_FIELD_W], 1'b0};
  assign imm8 = DATA_W'(instr[7:0]);
  assign in_ready = (state == IDLE) & ~reset;
  assign out_valid = state == DONE;
  assign accept = in_valid & in_ready & ~flush;
  assign rot_go = (imm_src == ROT8) && (amt != '0);
  assign step = (rem > AW'(ROT_STEP)) ? SW'(ROT_STEP) : SW'(rem);
  assign last = rem == AW'(step);
  // ROT8 loads the unrotated byte; the rotator works on ext_imm in place
  assign final_imm = imm_src == ROT8   ? imm8 :
                     imm_src == ZEXT12 ? DATA_W'(instr[11:0]) :
                     imm_src == BRANCH ? {{(DATA_W-26){instr[23]}}, instr, 2'b00} :
                     imm_src == HALF8  ? DATA_W'({instr[11:8], instr[3:0]}) :
                     imm_src == SEXT12 ? {{(DATA_W-12){instr[11]}}, instr[11:0]} : '0;
  ror_step #(.DATA_W(DATA_W), .ROT_STEP(ROT_STEP)) u_ror (
    .din  (ext_imm),
    .amt  (step),
    .dout (rot)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = flush           ? IDLE :
               state == IDLE   ? (accept ? (rot_go ? ROT : DONE) : IDLE) :
               state == ROT    ? (last ? DONE : ROT) :
               out_ready       ? IDLE : DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_imm   <= '0;
      carry_out <= 1'b0;
      illegal   <= 1'b0;
      rem       <= '0;
    end else if (accept) begin
      ext_imm   <= final_imm;
      carry_out <= carry_in;
      illegal   <= imm_src > SEXT12;
      rem       <= rot_go ? amt : '0;
    end else if (state == ROT && !flush) begin
      ext_imm <= rot;
      rem     <= rem - AW'(step);
      if (last) carry_out <= rot[DATA_W-1];
    end
  end
endmodule

// File: tb/tb_imm_extend_seq.sv
// tb_imm_extend_seq: directed vectors checked against a per-cycle behavioural model and literals
module tb_imm_extend_seq;
  localparam int RS = 2;
  logic clk = 0;
  logic reset, in_valid, in_valid16, flush, out_ready, carry_in;
  logic [23:0] instr;
  logic [2:0] imm_src;
  logic in_ready, out_valid, carry_out, illegal;
  logic in_ready16, out_valid16, carry_out16, illegal16;
  logic [31:0] ext_imm, ext_imm16;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  imm_extend_seq #(.DATA_W(32), .ROT_STEP(RS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .imm_src(imm_src), .carry_in(carry_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .ext_imm(ext_imm), .carry_out(carry_out), .illegal(illegal)
  );
  imm_extend_seq #(.DATA_W(32), .ROT_STEP(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16), .instr(instr),
    .imm_src(imm_src), .carry_in(carry_in), .flush(flush), .out_valid(out_valid16),
    .out_ready(out_ready), .ext_imm(ext_imm16), .carry_out(carry_out16), .illegal(illegal16)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [2:0] s, input logic [23:0] i);
    logic [31:0] r;
    case (s)
      3'd0: begin
        r = {24'h0, i[7:0]};
        repeat (2 * int'(i[11:8])) r = {r[0], r[31:1]};
        return r;
      end
      3'd1: return {20'h0, i[11:0]};
      3'd2: return {{6{i[23]}}, i, 2'b00};
      3'd3: return {24'h0, i[11:8], i[3:0]};
      3'd4: return {{20{i[11]}}, i[11:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_k(input logic [2:0] s, input logic [23:0] i, input int step);
    int a;
    a = 2 * int'(i[11:8]);
    return (s == 3'd0) ? (a + step - 1) / step : 0;
  endfunction

  function automatic logic ref_c(input logic [2:0] s, input logic [23:0] i, input logic c);
    return (s == 3'd0 && i[11:8] != 4'h0) ? ref_imm(s, i)[31] : c;
  endfunction

  // model state: waiting out k rotate cycles, then holding a result until consumed
  logic m_busy = 0, m_valid = 0, m_clean = 1, m_ill = 0, m_carry = 0;
  logic [31:0] m_imm = 0;
  int m_cnt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_valid = 0; m_cnt = 0; m_clean = 1;
    end else if (flush) begin
      m_busy = 0; m_valid = 0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin m_busy = 0; m_valid = 1; end
    end else if (in_valid) begin
      m_imm = ref_imm(imm_src, instr);
      m_carry = ref_c(imm_src, instr, carry_in);
      m_ill = imm_src > 3'd4;
      m_cnt = ref_k(imm_src, instr, RS);
      m_clean = 0;
      if (m_cnt == 0) m_valid = 1; else m_busy = 1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_busy && !m_valid && !reset);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("ext_imm", ext_imm, m_imm);
      chk("carry_out", carry_out, m_carry);
      chk("illegal", illegal, m_ill);
    end else if (m_clean) begin
      chk("rst_ext_imm", ext_imm, 0);
      chk("rst_carry", carry_out, 0);
      chk("rst_illegal", illegal, 0);
    end
  end

  typedef struct {
    logic [2:0] s; logic [23:0] i; logic c; logic [31:0] e; logic ec; logic ei; int k;
  } vec_t;
  vec_t v[11] = '{
    '{3'd0, 24'h0004FF, 1'b0, 32'hFF000000, 1'b1, 1'b0, 4},
    '{3'd0, 24'h0000AB, 1'b1, 32'h000000AB, 1'b1, 1'b0, 0},
    '{3'd2, 24'hFFFFFE, 1'b0, 32'hFFFFFFF8, 1'b0, 1'b0, 0},
    '{3'd1, 24'h000ABC, 1'b1, 32'h00000ABC, 1'b1, 1'b0, 0},
    '{3'd4, 24'h000800, 1'b0, 32'hFFFFF800, 1'b0, 1'b0, 0},
    '{3'd3, 24'h000A05, 1'b0, 32'h000000A5, 1'b0, 1'b0, 0},
    '{3'd6, 24'h000123, 1'b1, 32'h00000000, 1'b1, 1'b1, 0},
    '{3'd0, 24'h000FFF, 1'b0, 32'h000003FC, 1'b0, 1'b0, 15},
    '{3'd0, 24'h0001FF, 1'b0, 32'hC000003F, 1'b1, 1'b0, 1},
    '{3'd0, 24'h000301, 1'b1, 32'h04000000, 1'b0, 1'b0, 3},
    '{3'd2, 24'h000001, 1'b1, 32'h00000004, 1'b1, 1'b0, 0}
  };

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input vec_t t, input int idx);
    int n;
    imm_src = t.s; instr = t.i; carry_in = t.c; in_valid = 1;
    tick;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin tick; n++; end
    chk($sformatf("latency%0d", idx), 64'(n), 64'(t.k));
    chk($sformatf("imm%0d", idx), ext_imm, t.e);
    chk($sformatf("carry%0d", idx), carry_out, t.ec);
    chk($sformatf("illegal%0d", idx), illegal, t.ei);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; in_valid = 0; in_valid16 = 0; flush = 0; out_ready = 1;
    carry_in = 0; instr = 0; imm_src = 0;
    tick; tick;
    reset = 0;
    #1;
    chk("ready_after_reset", in_ready, 1);
    tick;
    foreach (v[j]) begin
      chk($sformatf("model_imm%0d", j), ref_imm(v[j].s, v[j].i), v[j].e);
      chk($sformatf("model_k%0d", j), 64'(ref_k(v[j].s, v[j].i, RS)), 64'(v[j].k));
      chk($sformatf("model_c%0d", j), ref_c(v[j].s, v[j].i, v[j].c), v[j].ec);
    end
    foreach (v[j]) begin
      send(v[j], j);
      tick;
    end
    // ROT_STEP=16 instance finishes a 0x4FF rotate one edge after accept
    imm_src = 3'd0; instr = 24'h0004FF; carry_in = 0; in_valid16 = 1;
    tick;
    in_valid16 = 0;
    chk("r16_busy", out_valid16, 0);
    tick;
    chk("r16_valid", out_valid16, 1);
    chk("r16_imm", ext_imm16, 32'hFF000000);
    chk("r16_carry", carry_out16, 1);
    tick;
    chk("r16_ready", in_ready16, 1);
    out_ready = 0;
    send(v[0], 100);
    repeat (5) begin
      tick;
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_imm", ext_imm, 32'hFF000000);
    end
    out_ready = 1;
    tick;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    send(v[2], 101);
    tick;
    imm_src = 3'd0; instr = 24'h000FFF; carry_in = 1; in_valid = 1;
    tick;
    in_valid = 0;
    tick; tick;
    reset = 1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_imm", ext_imm, 0);
    chk("rst_mid_carry", carry_out, 0);
    chk("rst_mid_ready", in_ready, 0);
    tick;
    reset = 0;
    repeat (20) tick;
    in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    flush = 1;
    tick;
    flush = 0;
    chk("flush_ready", in_ready, 1);
    chk("flush_valid", out_valid, 0);
    repeat (20) tick;
    imm_src = 3'd1; instr = 24'h000ABC; in_valid = 1; flush = 1;
    tick;
    in_valid = 0; flush = 0;
    chk("flush_wins", in_ready, 1);
    repeat (3) tick;
    send(v[3], 102);
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
